// File: rtl/simple_dual_port_lutram.sv
// Simple dual-port distributed RAM: one byte-masked write and one registered
// read per cycle, with a sequential clear engine that runs after reset and on
// flush. The array itself carries no reset.
// Optional build macro LUTRAM_PARITY_EN adds one even-parity bit per byte lane
// and a parity_error_out port aligned with read_valid_out.
//
// state | meaning
// CLEAR | clear engine zeroing one entry per cycle, ports blocked
// IDLE  | normal operation, write and read ports serviced
module simple_dual_port_lutram #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS                 = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
  parameter int BYTE_EN_WIDTH               = SINGLE_ELEMENT_SIZE_IN_BITS / 8,
  parameter int WRITE_FIRST                 = 0
) (
  input  logic                                   clk_in,
  input  logic                                   reset_n_in,
  input  logic                                   flush_in,
  output logic                                   busy_out,
  input  logic                                   write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       write_set_addr_in,
  input  logic [BYTE_EN_WIDTH-1:0]               write_byte_en_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_element_in,
  input  logic                                   read_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       read_set_addr_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_element_out,
  output logic                                   read_valid_out
`ifdef LUTRAM_PARITY_EN
  ,
  output logic [BYTE_EN_WIDTH-1:0]               parity_error_out
`endif
);

  localparam int W  = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int AW = SET_PTR_WIDTH_IN_BITS;
  localparam int BW = BYTE_EN_WIDTH;
  // One extra bit so the range check also works when NUMBER_SETS is a power of two.
  localparam logic [AW:0]   NUM_SETS_EXT = (AW + 1)'(NUMBER_SETS);
  localparam logic [AW-1:0] LAST_SET     = AW'(NUMBER_SETS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clear_ptr_q, clear_ptr_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic [W-1:0]  lutram_q [NUMBER_SETS];

  logic          idle;
  logic          wr_in_range, rd_in_range;
  logic          wr_fire, rd_fire, same_addr;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_mask;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  rd_old, rd_merged;

  assign idle        = (state_q == ST_IDLE);
  assign wr_in_range = ({1'b0, write_set_addr_in} < NUM_SETS_EXT);
  assign rd_in_range = ({1'b0, read_set_addr_in} < NUM_SETS_EXT);
  assign wr_fire     = idle && write_en_in && wr_in_range;
  assign rd_fire     = idle && read_en_in;
  assign same_addr   = (write_set_addr_in == read_set_addr_in);
  assign busy_out    = ~idle;

  // Next-state logic for the clear engine; flush is only honoured from IDLE.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (clear_ptr_q == LAST_SET) begin
          state_d     = ST_IDLE;
          clear_ptr_d = '0;
        end else begin
          clear_ptr_d = clear_ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (flush_in) begin
          state_d     = ST_CLEAR;
          clear_ptr_d = '0;
        end
      end
      default: begin
        state_d     = ST_CLEAR;
        clear_ptr_d = '0;
      end
    endcase
  end

  // Array write port: clear engine owns it while busy, otherwise the user write.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = write_set_addr_in;
    mem_mask  = write_byte_en_in;
    mem_wdata = write_element_in;
    if (!idle) begin
      mem_we    = 1'b1;
      mem_addr  = clear_ptr_q;
      mem_mask  = '1;
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  // Read path: old entry, optionally overlaid with same-cycle write bytes.
  always_comb begin
    rd_old    = rd_in_range ? lutram_q[read_set_addr_in] : '0;
    rd_merged = rd_old;
    if ((WRITE_FIRST != 0) && wr_fire && same_addr) begin
      for (int i = 0; i < BW; i++) begin
        if (write_byte_en_in[i]) rd_merged[8*i +: 8] = write_element_in[8*i +: 8];
      end
    end
    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? rd_merged : rd_data_q;
  end

  // Distributed RAM storage, deliberately without reset.
  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      for (int i = 0; i < BW; i++) begin
        if (mem_mask[i]) lutram_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Control and read-output registers.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign read_element_out = rd_data_q;
  assign read_valid_out   = rd_valid_q;

`ifdef LUTRAM_PARITY_EN
  logic [BW-1:0] parity_q [NUMBER_SETS];
  logic [BW-1:0] mem_wpar;
  logic [BW-1:0] rd_par_merged;
  logic [BW-1:0] par_err_q, par_err_d;

  // Even parity per lane of whatever is being written (zero data gives zero parity).
  always_comb begin
    mem_wpar = '0;
    for (int i = 0; i < BW; i++) begin
      mem_wpar[i] = ^mem_wdata[8*i +: 8];
    end
  end

  // Check parity of the returned word against stored (or freshly written) parity.
  always_comb begin
    rd_par_merged = rd_in_range ? parity_q[read_set_addr_in] : '0;
    if ((WRITE_FIRST != 0) && wr_fire && same_addr) begin
      for (int i = 0; i < BW; i++) begin
        if (write_byte_en_in[i]) rd_par_merged[i] = ^write_element_in[8*i +: 8];
      end
    end
    par_err_d = '0;
    for (int i = 0; i < BW; i++) begin
      par_err_d[i] = rd_fire && ((^rd_merged[8*i +: 8]) ^ rd_par_merged[i]);
    end
  end

  // Parity storage, written alongside its data byte.
  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      for (int i = 0; i < BW; i++) begin
        if (mem_mask[i]) parity_q[mem_addr][i] <= mem_wpar[i];
      end
    end
  end

  // Registered parity error flags, aligned with read_valid_out.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) par_err_q <= '0;
    else             par_err_q <= par_err_d;
  end

  assign parity_error_out = par_err_q;
`endif

endmodule

// File: tb/tb_simple_dual_port_lutram.sv
// Bench for simple_dual_port_lutram: three instances share stimulus
// (64 sets read-first, 64 sets write-first, 48 sets read-first) and are
// checked against a reference model through an expected-result queue.
module tb_simple_dual_port_lutram;

  typedef struct packed {
    logic [2:0]       v;
    logic [2:0][63:0] d;
    logic [2:0][7:0]  p;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [5:0]  waddr = '0;
  logic [5:0]  raddr = '0;
  logic [7:0]  wmask = '0;
  logic [63:0] wdata = '0;

  logic [63:0] rd_o [3];
  logic [2:0]  v_o;
  logic [2:0]  b_o;
  logic [7:0]  perr_o [3];

  logic [63:0] mm [3][64];
  logic [7:0]  pm [3][64];
  int          bcnt [3];
  logic [63:0] last_d [3];
  exp_t        q [$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  simple_dual_port_lutram dut (
    .clk_in(clk), .reset_n_in(rst_n), .flush_in(flush), .busy_out(b_o[0]),
    .write_en_in(we), .write_set_addr_in(waddr), .write_byte_en_in(wmask),
    .write_element_in(wdata), .read_en_in(re), .read_set_addr_in(raddr),
    .read_element_out(rd_o[0]), .read_valid_out(v_o[0])
`ifdef LUTRAM_PARITY_EN
    , .parity_error_out(perr_o[0])
`endif
  );

  simple_dual_port_lutram #(.WRITE_FIRST(1)) dut_wf (
    .clk_in(clk), .reset_n_in(rst_n), .flush_in(flush), .busy_out(b_o[1]),
    .write_en_in(we), .write_set_addr_in(waddr), .write_byte_en_in(wmask),
    .write_element_in(wdata), .read_en_in(re), .read_set_addr_in(raddr),
    .read_element_out(rd_o[1]), .read_valid_out(v_o[1])
`ifdef LUTRAM_PARITY_EN
    , .parity_error_out(perr_o[1])
`endif
  );

  simple_dual_port_lutram #(.NUMBER_SETS(48)) dut_np (
    .clk_in(clk), .reset_n_in(rst_n), .flush_in(flush), .busy_out(b_o[2]),
    .write_en_in(we), .write_set_addr_in(waddr), .write_byte_en_in(wmask),
    .write_element_in(wdata), .read_en_in(re), .read_set_addr_in(raddr),
    .read_element_out(rd_o[2]), .read_valid_out(v_o[2])
`ifdef LUTRAM_PARITY_EN
    , .parity_error_out(perr_o[2])
`endif
  );

`ifndef LUTRAM_PARITY_EN
  assign perr_o[0] = '0;
  assign perr_o[1] = '0;
  assign perr_o[2] = '0;
`endif

  function automatic int ns(input int k);
    return (k == 2) ? 48 : 64;
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, expv);
    end
  endtask

  task automatic model_zero(input int k);
    for (int a = 0; a < 64; a++) begin
      mm[k][a] = '0;
      pm[k][a] = '0;
    end
  endtask

  // One clock: compute expectations from the model, advance it, then compare.
  task automatic step();
    exp_t        e;
    exp_t        got;
    logic [63:0] d;
    logic [7:0]  p;
    bit          busy;
    bit          wr_ok;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      busy  = (bcnt[k] > 0);
      wr_ok = !busy && we && (int'(waddr) < ns(k));
      if (!busy && re) begin
        d = '0;
        p = '0;
        if (int'(raddr) < ns(k)) begin
          d = mm[k][raddr];
          p = pm[k][raddr];
          if (k == 1 && wr_ok && waddr == raddr) begin
            for (int i = 0; i < 8; i++) begin
              if (wmask[i]) begin
                d[8*i +: 8] = wdata[8*i +: 8];
                p[i] = 1'b0;
              end
            end
          end
        end
        e.v[k] = 1'b1;
        e.d[k] = d;
        e.p[k] = p;
        last_d[k] = d;
      end else begin
        e.v[k] = 1'b0;
        e.d[k] = last_d[k];
        e.p[k] = '0;
      end
      if (wr_ok) begin
        for (int i = 0; i < 8; i++) begin
          if (wmask[i]) begin
            mm[k][waddr][8*i +: 8] = wdata[8*i +: 8];
            pm[k][waddr][i] = 1'b0;
          end
        end
      end
      if (busy) bcnt[k]--;
      else if (flush) begin
        bcnt[k] = ns(k);
        model_zero(k);
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    for (int k = 0; k < 3; k++) begin
      chk("valid", k, 64'(v_o[k]), 64'(got.v[k]));
      chk("data", k, rd_o[k], got.d[k]);
      chk("busy", k, 64'(b_o[k]), 64'(bcnt[k] > 0));
`ifdef LUTRAM_PARITY_EN
      chk("perr", k, 64'(perr_o[k]), 64'(got.p[k]));
`endif
    end
  endtask

  task automatic cyc(input bit w, input logic [5:0] wa, input logic [7:0] wm,
                     input logic [63:0] wd, input bit r, input logic [5:0] ra, input bit f);
    we = w; waddr = wa; wmask = wm; wdata = wd; re = r; raddr = ra; flush = f;
    step();
    we = 1'b0; re = 1'b0; flush = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, '0, 0, '0, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, 64'(v_o[k]), 64'd0);
      chk("rst_data", k, rd_o[k], 64'd0);
      chk("rst_busy", k, 64'(b_o[k]), 64'd1);
      chk("rst_perr", k, 64'(perr_o[k]), 64'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    for (int k = 0; k < 3; k++) begin
      bcnt[k] = ns(k);
      last_d[k] = '0;
      model_zero(k);
    end
  endtask

  initial begin
    do_reset();
    // Power-up clear: 64 (48) busy cycles.
    idle_cycles(64);
    cyc(0, '0, '0, '0, 1, 6'd63, 0);
    idle_cycles(1);

    // Masked byte writes.
    cyc(1, 6'd5, 8'hFF, 64'h1122334455667788, 0, '0, 0);
    cyc(1, 6'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 0, '0, 0);
    cyc(0, '0, '0, '0, 1, 6'd5, 0);
    // Zero mask is a no-op.
    cyc(1, 6'd5, 8'h00, 64'hDEADBEEFDEADBEEF, 0, '0, 0);
    cyc(0, '0, '0, '0, 1, 6'd5, 0);

    // Same-address read during write, then independent addresses.
    cyc(1, 6'd9, 8'h03, 64'h000000000000FFFF, 1, 6'd9, 0);
    cyc(0, '0, '0, '0, 1, 6'd9, 0);
    cyc(1, 6'd10, 8'hF0, 64'h0123456789ABCDEF, 1, 6'd5, 0);
    cyc(0, '0, '0, '0, 1, 6'd10, 0);
    cyc(1, 6'd5, 8'h81, 64'hCAFE0000000000BE, 1, 6'd5, 0);
    cyc(0, '0, '0, '0, 0, '0, 0);

    // Out-of-range for the 48-entry instance.
    cyc(1, 6'd50, 8'hFF, 64'h5050505050505050, 0, '0, 0);
    cyc(0, '0, '0, '0, 1, 6'd50, 0);
    cyc(0, '0, '0, '0, 1, 6'd47, 0);

    // Fill every entry while reading back the previous one.
    for (int a = 0; a < 64; a++) begin
      cyc(1, 6'(a), 8'hFF, {$urandom, $urandom}, a > 0, 6'(a - 1), 0);
    end
    cyc(0, '0, '0, '0, 1, 6'd63, 0);

    // Flush with a same-cycle write and read, then blocked requests.
    cyc(1, 6'd3, 8'hFF, 64'h3333333333333333, 1, 6'd3, 1);
    cyc(1, 6'd4, 8'hFF, 64'h4444444444444444, 1, 6'd4, 0);
    cyc(1, 6'd6, 8'hFF, 64'h6666666666666666, 1, 6'd6, 1);
    for (int i = 0; i < 8; i++) cyc(1, 6'(i), 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1, 6'(i + 8), 0);
    for (int i = 0; i < 64 && (bcnt[0] > 0 || bcnt[1] > 0 || bcnt[2] > 0); i++) idle_cycles(1);
    for (int a = 0; a <= 64; a++) cyc(0, '0, '0, '0, a < 64, 6'(a), 0);

`ifdef LUTRAM_PARITY_EN
    // Corrupt bit 3 of byte 2 at address 7 behind the parity logic.
    cyc(1, 6'd7, 8'hFF, 64'h0706050403020100, 0, '0, 0);
    dut.lutram_q[7][19]    = ~dut.lutram_q[7][19];
    dut_wf.lutram_q[7][19] = ~dut_wf.lutram_q[7][19];
    dut_np.lutram_q[7][19] = ~dut_np.lutram_q[7][19];
    for (int k = 0; k < 3; k++) begin
      mm[k][7][19] = ~mm[k][7][19];
      pm[k][7][2]  = 1'b1;
    end
    cyc(0, '0, '0, '0, 1, 6'd7, 0);
    cyc(0, '0, '0, '0, 1, 6'd6, 0);
`endif

    // Reset in the middle of a clear.
    cyc(1, 6'd20, 8'hFF, 64'h2020202020202020, 0, '0, 0);
    cyc(0, '0, '0, '0, 1, 6'd20, 0);
    cyc(0, '0, '0, '0, 0, '0, 1);
    idle_cycles(30);
    do_reset();
    idle_cycles(64);
    cyc(0, '0, '0, '0, 1, 6'd20, 0);
    cyc(0, '0, '0, '0, 1, 6'd63, 0);
    idle_cycles(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
